// File: rtl/c_fetch_align_if.sv
// Fetch-side and decode-side handshakes of the fetch aligner, plus redirect and occupancy.
// The slave modport is the aligner; the master modport is whatever surrounds it.
interface c_fetch_align_if #(
   parameter int BUF_HW = 6
);
   localparam int OCC_W = $clog2(BUF_HW + 1);

   logic             flush_i;
   logic [31:0]      flush_pc_i;
   logic             fetch_valid_i;
   logic [31:0]      fetch_data_i;
   logic             fetch_ready_o;
   logic             instr_valid_o;
   logic             instr_ready_i;
   logic [31:0]      instr_o;
   logic [31:0]      instr_pc_o;
   logic             instr_is_comp_o;
   logic             instr_illegal_o;
   logic [OCC_W-1:0] occ_o;

   modport slave (
      input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, instr_ready_i,
      output fetch_ready_o, instr_valid_o, instr_o, instr_pc_o,
             instr_is_comp_o, instr_illegal_o, occ_o
   );

   modport master (
      output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, instr_ready_i,
      input  fetch_ready_o, instr_valid_o, instr_o, instr_pc_o,
             instr_is_comp_o, instr_illegal_o, occ_o
   );
endinterface

// File: rtl/c_fetch_align.sv
// Fetch aligner: buffers 32-bit fetch words as 16-bit parcels, reassembles instructions that
// straddle words, expands RV32C parcels and hands one instruction plus its PC to decode.
module c_fetch_align #(
   parameter int          BUF_HW   = 6,
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter bit          RVC_EN   = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   c_fetch_align_if.slave bus
);
   localparam int PTR_W = $clog2(BUF_HW);
   localparam int CNT_W = $clog2(BUF_HW + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_ROOM = CNT_W'(BUF_HW - 2);
   localparam logic [31:0]      NOP      = 32'h0000_0013;

   logic [15:0]      parcel_mem [BUF_HW];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      head_pc;
   logic             drop_first;

   logic [15:0]      h0, h1;
   logic             is32, head_valid, push, pop;
   logic [CNT_W-1:0] push_cnt, pop_cnt;
   logic [32:0]      expanded;
   logic             comp_illegal;
   logic             unused_flush_pc_lsb;

   function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] p, input logic two);
      logic [PTR_W:0] s;
      s = {1'b0, p} + (two ? (PTR_W+1)'(2) : (PTR_W+1)'(1));
      if (s >= (PTR_W+1)'(BUF_HW)) s = s - (PTR_W+1)'(BUF_HW);
      return s[PTR_W-1:0];
   endfunction

   // Returns {illegal, 32-bit equivalent}; illegal forms yield the canonical NOP.
   function automatic logic [32:0] expand(input logic [15:0] p);
      logic [4:0]  rd, rs2, rdp, rs2p;
      logic [11:0] imm6;
      logic        ill;
      logic [31:0] ins;
      rd   = p[11:7];
      rs2  = p[6:2];
      rdp  = {2'b01, p[9:7]};
      rs2p = {2'b01, p[4:2]};
      imm6 = {{7{p[12]}}, p[6:2]};
      ill  = 1'b0;
      ins  = NOP;
      case ({p[1:0], p[15:13]})
         5'b00_000: begin
            ins = {2'b00, p[10:7], p[12:11], p[5], p[6], 2'b00, 5'd2, 3'b000, rs2p, 7'h13};
            ill = (p[12:5] == 8'd0);
         end
         5'b00_010: ins = {5'b0, p[5], p[12:10], p[6], 2'b00, rdp, 3'b010, rs2p, 7'h03};
         5'b00_110: ins = {5'b0, p[5], p[12], rs2p, rdp, 3'b010, p[11:10], p[6], 2'b00, 7'h23};
         5'b01_000: ins = {imm6, rd, 3'b000, rd, 7'h13};
         5'b01_001: ins = {p[12], p[8], p[10:9], p[6], p[7], p[2], p[11], p[5:3], p[12],
                           {8{p[12]}}, 5'd1, 7'h6f};
         5'b01_010: ins = {imm6, 5'd0, 3'b000, rd, 7'h13};
         5'b01_011: begin
            ill = ({p[12], p[6:2]} == 6'd0);
            if (rd == 5'd2)
               ins = {{3{p[12]}}, p[4:3], p[5], p[2], p[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
            else
               ins = {{15{p[12]}}, p[6:2], rd, 7'h37};
         end
         5'b01_100: begin
            case (p[11:10])
               2'b00: begin ins = {7'b0000000, p[6:2], rdp, 3'b101, rdp, 7'h13}; ill = p[12]; end
               2'b01: begin ins = {7'b0100000, p[6:2], rdp, 3'b101, rdp, 7'h13}; ill = p[12]; end
               2'b10: ins = {imm6, rdp, 3'b111, rdp, 7'h13};
               default: begin
                  ill = p[12];
                  case (p[6:5])
                     2'b00:   ins = {7'b0100000, rs2p, rdp, 3'b000, rdp, 7'h33};
                     2'b01:   ins = {7'b0000000, rs2p, rdp, 3'b100, rdp, 7'h33};
                     2'b10:   ins = {7'b0000000, rs2p, rdp, 3'b110, rdp, 7'h33};
                     default: ins = {7'b0000000, rs2p, rdp, 3'b111, rdp, 7'h33};
                  endcase
               end
            endcase
         end
         5'b01_101: ins = {p[12], p[8], p[10:9], p[6], p[7], p[2], p[11], p[5:3], p[12],
                           {8{p[12]}}, 5'd0, 7'h6f};
         5'b01_110: ins = {p[12], {3{p[12]}}, p[6:5], p[2], 5'd0, rdp, 3'b000, p[11:10], p[4:3],
                           p[12], 7'h63};
         5'b01_111: ins = {p[12], {3{p[12]}}, p[6:5], p[2], 5'd0, rdp, 3'b001, p[11:10], p[4:3],
                           p[12], 7'h63};
         5'b10_000: begin ins = {7'b0, p[6:2], rd, 3'b001, rd, 7'h13}; ill = p[12]; end
         5'b10_010: begin
            ins = {4'b0, p[3:2], p[12], p[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
            ill = (rd == 5'd0);
         end
         5'b10_100: begin
            if (!p[12]) begin
               if (rs2 == 5'd0) begin
                  ins = {12'b0, rd, 3'b000, 5'd0, 7'h67};
                  ill = (rd == 5'd0);
               end else
                  ins = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
            end else if (rs2 == 5'd0) begin
               ins = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'h67};
            end else
               ins = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
         end
         5'b10_110: ins = {4'b0, p[8:7], p[12], rs2, 5'd2, 3'b010, p[11:9], 2'b00, 7'h23};
         default:   ill = 1'b1;
      endcase
      if (ill) ins = NOP;
      return {ill, ins};
   endfunction

   assign unused_flush_pc_lsb = bus.flush_pc_i[0];

   assign h0         = parcel_mem[rd_ptr];
   assign h1         = parcel_mem[ptr_step(rd_ptr, 1'b0)];
   assign is32       = (h0[1:0] == 2'b11);
   assign head_valid = (count != CNT_ZERO) & (~is32 | (count >= CNT_TWO));

   assign bus.fetch_ready_o = (count <= CNT_ROOM) & ~bus.flush_i;
   assign push     = bus.fetch_valid_i & bus.fetch_ready_o;
   assign pop      = head_valid & bus.instr_ready_i;
   assign push_cnt = push ? (drop_first ? CNT_ONE : CNT_TWO) : CNT_ZERO;
   assign pop_cnt  = pop ? (is32 ? CNT_TWO : CNT_ONE) : CNT_ZERO;

   assign expanded     = expand(h0);
   assign comp_illegal = ~RVC_EN | expanded[32];

   assign bus.instr_valid_o   = head_valid;
   assign bus.instr_pc_o      = head_pc;
   assign bus.instr_is_comp_o = head_valid & ~is32;
   assign bus.instr_illegal_o = head_valid & ~is32 & comp_illegal;
   assign bus.occ_o           = count;

   always_comb begin
      bus.instr_o = NOP;
      if (head_valid) begin
         if (is32)               bus.instr_o = {h1, h0};
         else if (!comp_illegal) bus.instr_o = expanded[31:0];
      end
   end

   // Parcel storage carries data only; occupancy and pointers decide what is meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         if (drop_first) begin
            parcel_mem[wr_ptr] <= bus.fetch_data_i[31:16];
         end else begin
            parcel_mem[wr_ptr]                   <= bus.fetch_data_i[15:0];
            parcel_mem[ptr_step(wr_ptr, 1'b0)]   <= bus.fetch_data_i[31:16];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= CNT_ZERO;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         head_pc    <= {RESET_PC[31:1], 1'b0};
         drop_first <= RESET_PC[1];
      end else if (bus.flush_i) begin
         count      <= CNT_ZERO;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         head_pc    <= {bus.flush_pc_i[31:1], 1'b0};
         drop_first <= bus.flush_pc_i[1];
      end else begin
         if (push) begin
            wr_ptr     <= ptr_step(wr_ptr, ~drop_first);
            drop_first <= 1'b0;
         end
         if (pop) begin
            rd_ptr  <= ptr_step(rd_ptr, is32);
            head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
         end
         count <= count + push_cnt - pop_cnt;
      end
   end
endmodule

// File: tb/tb_c_fetch_align.sv
// Bench for c_fetch_align: directed scenarios plus randomized instruction streams, checked by a
// scoreboard fed from an ISA-level encoder model.
`timescale 1ns/1ps
module tb_c_fetch_align;
   localparam int          BUF_HW   = 6;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   c_fetch_align_if #(.BUF_HW(BUF_HW)) bus ();

   c_fetch_align #(.BUF_HW(BUF_HW), .RESET_PC(RESET_PC), .RVC_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   exp_t        exp_q[$];
   logic [15:0] par_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_pc;
   int          rdy_mode = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_ins(input logic [31:0] ins, input logic comp, input logic ill);
      exp_t e;
      e.instr = ins; e.pc = model_pc; e.comp = comp; e.ill = ill;
      exp_q.push_back(e);
      model_pc += comp ? 32'd2 : 32'd4;
   endtask

   // ISA encoders: expected results come from field values, not from parcel bit shuffles.
   function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      logic [11:0] i;
      i = imm[11:0];
      return {i, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input int off, input logic [4:0] rd);
      logic [20:0] o;
      o = off[20:0];
      return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs1, input logic [2:0] f3);
      logic [12:0] o;
      o = off[12:0];
      return {o[12], o[10:5], 5'd0, rs1, f3, o[4:1], o[11], 7'h63};
   endfunction

   task automatic gen_one();
      logic [31:0] w;
      logic [15:0] p;
      logic [11:0] o;
      logic [5:0]  i6;
      logic [4:0]  rd, rs2;
      logic [2:0]  rs1p;
      logic        alt;
      int          imm, off, k;
      k   = $urandom_range(0, 7);
      rd  = 5'($urandom_range(1, 31));
      rs2 = 5'($urandom_range(1, 31));
      alt = 1'($urandom_range(0, 1));
      case (k)
         0, 1: begin
            w = $urandom;
            w[1:0] = 2'b11;
            par_q.push_back(w[15:0]);
            par_q.push_back(w[31:16]);
            expect_ins(w, 1'b0, 1'b0);
            return;
         end
         2: begin
            imm = int'($urandom_range(0, 63)) - 32;
            i6  = imm[5:0];
            p   = {3'b010, i6[5], rd, i6[4:0], 2'b01};
            expect_ins(enc_i(imm, 5'd0, 3'b000, rd, 7'h13), 1'b1, 1'b0);
         end
         3: begin
            p = {3'b100, alt, rd, rs2, 2'b10};
            expect_ins({7'b0, rs2, alt ? rd : 5'd0, 3'b000, rd, 7'h33}, 1'b1, 1'b0);
         end
         4: begin
            off = (int'($urandom_range(0, 2047)) - 1024) * 2;
            o   = off[11:0];
            p   = {alt ? 3'b001 : 3'b101, o[11], o[4], o[9:8], o[10], o[6], o[7], o[3:1], o[5], 2'b01};
            expect_ins(enc_j(off, alt ? 5'd1 : 5'd0), 1'b1, 1'b0);
         end
         5: begin
            off  = (int'($urandom_range(0, 255)) - 128) * 2;
            o    = off[11:0];
            rs1p = 3'($urandom_range(0, 7));
            p    = {alt ? 3'b111 : 3'b110, o[8], o[4:3], rs1p, o[7:6], o[2:1], o[5], 2'b01};
            expect_ins(enc_b(off, {2'b01, rs1p}, alt ? 3'b001 : 3'b000), 1'b1, 1'b0);
         end
         6: begin
            case ($urandom_range(0, 3))
               0:       p = 16'h0000;
               1:       p = {3'b011, 1'b0, (rd == 5'd2) ? 5'd3 : rd, 5'd0, 2'b01};
               2:       p = {3'b000, 1'b1, rd, rs2, 2'b10};
               default: p = 16'h8002;
            endcase
            expect_ins(32'h0000_0013, 1'b1, 1'b1);
         end
         default: begin
            imm = int'($urandom_range(0, 63)) - 32;
            i6  = imm[5:0];
            p   = {3'b000, i6[5], rd, i6[4:0], 2'b01};
            expect_ins(enc_i(imm, rd, 3'b000, rd, 7'h13), 1'b1, 1'b0);
         end
      endcase
      par_q.push_back(p);
   endtask

   // Sole driver of instr_ready_i: 0 low, 1 high, 2 random.
   initial begin
      bus.instr_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.instr_ready_i = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
      end
   end

   exp_t        mon_e;
   logic        stall_prev = 1'b0;
   logic [31:0] hold_instr, hold_pc;
   logic [1:0]  hold_flags;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && bus.instr_valid_o) begin
            chk("hold_instr", bus.instr_o, hold_instr);
            chk("hold_pc", bus.instr_pc_o, hold_pc);
            chk("hold_flags", {30'b0, bus.instr_is_comp_o, bus.instr_illegal_o}, {30'b0, hold_flags});
         end
         if (!bus.instr_valid_o) begin
            chk("idle_instr", bus.instr_o, 32'h0000_0013);
            chk("idle_flags", {30'b0, bus.instr_is_comp_o, bus.instr_illegal_o}, 32'd0);
         end else if (bus.instr_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr actual=%h@%h required=none", bus.instr_o, bus.instr_pc_o);
            end else begin
               mon_e = exp_q.pop_front();
               chk("instr", bus.instr_o, mon_e.instr);
               chk("pc", bus.instr_pc_o, mon_e.pc);
               chk("flags", {30'b0, bus.instr_is_comp_o, bus.instr_illegal_o},
                   {30'b0, mon_e.comp, mon_e.ill});
            end
         end
         stall_prev = bus.instr_valid_o & ~bus.instr_ready_i;
         hold_instr = bus.instr_o;
         hold_pc    = bus.instr_pc_o;
         hold_flags = {bus.instr_is_comp_o, bus.instr_illegal_o};
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_word(input logic [31:0] w);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      bus.fetch_valid_i = 1'b1;
      bus.fetch_data_i  = w;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = bus.fetch_ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      bus.fetch_valid_i = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=stalled required=accepted word %h", w);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_flush(input logic [31:0] tgt, input logic with_push);
      bus.flush_i       = 1'b1;
      bus.flush_pc_i    = tgt;
      bus.fetch_valid_i = with_push;
      bus.fetch_data_i  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("flush_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
      @(posedge clk);
      #1;
      bus.flush_i       = 1'b0;
      bus.fetch_valid_i = 1'b0;
      model_pc          = {tgt[31:1], 1'b0};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tgt;
      int          g;
      bus.flush_i       = 1'b0;
      bus.flush_pc_i    = '0;
      bus.fetch_valid_i = 1'b0;
      bus.fetch_data_i  = '0;
      model_pc          = RESET_PC;

      // Reset values
      #12;
      chk("rst_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      chk("rst_fready", {31'b0, bus.fetch_ready_o}, 32'd1);
      chk("rst_pc", bus.instr_pc_o, RESET_PC);
      chk("rst_occ", 32'(bus.occ_o), 32'd0);
      chk("rst_instr", bus.instr_o, 32'h0000_0013);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Two compressed parcels in one word; valid the cycle after the push
      expect_ins(32'h0000_0513, 1'b1, 1'b0);
      expect_ins(32'h0010_0613, 1'b1, 1'b0);
      push_word(32'h4605_4501);
      @(negedge clk);
      chk("latency_valid", {31'b0, bus.instr_valid_o}, 32'd1);
      drain();

      // Straddling 32-bit instruction
      expect_ins(32'h0000_0513, 1'b1, 1'b0);
      expect_ins(32'h0000_0513, 1'b0, 1'b0);
      expect_ins(32'h0010_0613, 1'b1, 1'b0);
      push_word(32'h0513_4501);
      @(negedge clk);
      @(negedge clk);
      chk("straddle_wait", {31'b0, bus.instr_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      push_word(32'h4605_0000);
      drain();

      // Redirect to an odd halfword with a simultaneous push that must be discarded
      do_flush(32'h8000_0103, 1'b1);
      @(negedge clk);
      chk("flush_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      chk("flush_occ", 32'(bus.occ_o), 32'd0);
      chk("flush_pc", bus.instr_pc_o, 32'h8000_0102);
      @(posedge clk);
      #1;
      expect_ins(32'h0010_0613, 1'b1, 1'b0);
      push_word(32'h4605_ABCD);
      drain();

      // Back-pressure fills the buffer
      rdy_mode = 0;
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         expect_ins(32'h0000_0513, 1'b1, 1'b0);
         expect_ins(32'h0010_0613, 1'b1, 1'b0);
      end
      for (int i = 0; i < 3; i++) push_word(32'h4605_4501);
      @(negedge clk);
      chk("full_occ", 32'(bus.occ_o), 32'd6);
      chk("full_fready", {31'b0, bus.fetch_ready_o}, 32'd0);
      repeat (3) @(negedge clk);
      rdy_mode = 1;
      drain();

      // Zero parcel is illegal and advances by 2
      expect_ins(32'h0000_0013, 1'b1, 1'b1);
      expect_ins(32'h0010_0613, 1'b1, 1'b0);
      push_word(32'h4605_0000);
      drain();

      // Randomized streams after random redirects
      for (int r = 0; r < 3; r++) begin
         tgt = $urandom;
         do_flush(tgt, 1'($urandom_range(0, 1)));
         if (tgt[1]) par_q.push_back(16'hBEEF);
         for (int i = 0; i < 150; i++) gen_one();
         if (par_q.size() % 2 != 0) begin
            par_q.push_back(16'h4001);
            expect_ins(32'h0000_0013, 1'b1, 1'b0);
         end
         rdy_mode = 2;
         while (par_q.size() >= 2) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(posedge clk);
               #1;
            end
            push_word({par_q[1], par_q[0]});
            void'(par_q.pop_front());
            void'(par_q.pop_front());
         end
         rdy_mode = 1;
         drain();
      end

      // Asynchronous reset in the middle of operation
      rdy_mode = 0;
      @(posedge clk);
      #2;
      push_word(32'h4605_4501);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_occ", 32'(bus.occ_o), 32'd0);
      chk("async_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      chk("async_pc", bus.instr_pc_o, RESET_PC);
      chk("async_fready", {31'b0, bus.fetch_ready_o}, 32'd1);
      @(negedge clk);
      rst_n    = 1'b1;
      rdy_mode = 1;
      model_pc = RESET_PC;
      @(posedge clk);
      #2;
      expect_ins(32'h0000_0513, 1'b1, 1'b0);
      expect_ins(32'h0010_0613, 1'b1, 1'b0);
      push_word(32'h4605_4501);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
